// File: rtl/dual_port_ram_arbiter.sv
// rtl/dual_port_ram_arbiter.sv - four-requester round-robin arbiter over a shared dual-port RAM
module dual_port_ram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              req,
   input  logic [3:0]              we,
   input  logic [4*ADDR_WIDTH-1:0] addr,
   input  logic [4*DATA_WIDTH-1:0] wdata,
   output logic [3:0]              gnt,
   output logic [3:0]              rvalid,
   output logic [4*DATA_WIDTH-1:0] rdata,
   output logic                    ram_en_0,
   output logic                    ram_en_1,
   output logic                    ram_we_0,
   output logic                    ram_we_1,
   output logic [ADDR_WIDTH-1:0]   ram_addr_0,
   output logic [ADDR_WIDTH-1:0]   ram_addr_1,
   output logic [DATA_WIDTH-1:0]   ram_din_0,
   output logic [DATA_WIDTH-1:0]   ram_din_1,
   input  logic [DATA_WIDTH-1:0]   ram_dout_0,
   input  logic [DATA_WIDTH-1:0]   ram_dout_1,
   output logic [7:0]              conflict_cnt
);

   logic [1:0]            ptr, ptr_next, sel0, sel1, idx;
   logic                  found0, found1, conflict, grant0, grant1;
   logic [ADDR_WIDTH-1:0] addr0, addr1;
   logic [DATA_WIDTH-1:0] data0, data1;
   logic                  tag_v0, tag_v1;
   logic [1:0]            tag_o0, tag_o1;
   logic [3:0]            ret;

   // First two requesters in rotating order starting at ptr
   always_comb begin
      found0 = 1'b0;
      found1 = 1'b0;
      sel0   = '0;
      sel1   = '0;
      idx    = '0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            if (!found0) begin
               found0 = 1'b1;
               sel0   = idx;
            end else if (!found1) begin
               found1 = 1'b1;
               sel1   = idx;
            end
         end
      end
   end

   assign addr0 = addr[sel0*ADDR_WIDTH +: ADDR_WIDTH];
   assign addr1 = addr[sel1*ADDR_WIDTH +: ADDR_WIDTH];
   assign data0 = wdata[sel0*DATA_WIDTH +: DATA_WIDTH];
   assign data1 = wdata[sel1*DATA_WIDTH +: DATA_WIDTH];

   // Same-address write pair: defer the second so the write order stays deterministic
   assign conflict = found0 && found1 && we[sel0] && we[sel1] && (addr0 == addr1);
   assign grant0   = found0 && !rst;
   assign grant1   = found1 && !conflict && !rst;

   always_comb begin
      gnt = '0;
      if (grant0) gnt[sel0] = 1'b1;
      if (grant1) gnt[sel1] = 1'b1;
   end

   assign ram_en_0   = grant0;
   assign ram_we_0   = grant0 && we[sel0];
   assign ram_addr_0 = grant0 ? addr0 : '0;
   assign ram_din_0  = grant0 ? data0 : '0;
   assign ram_en_1   = grant1;
   assign ram_we_1   = grant1 && we[sel1];
   assign ram_addr_1 = grant1 ? addr1 : '0;
   assign ram_din_1  = grant1 ? data1 : '0;

   always_comb begin
      if (grant1)      ptr_next = sel1 + 2'd1;
      else if (grant0) ptr_next = sel0 + 2'd1;
      else             ptr_next = ptr;
   end

   always_comb begin
      ret = '0;
      if (tag_v0) ret[tag_o0] = 1'b1;
      if (tag_v1) ret[tag_o1] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr          <= '0;
         tag_v0       <= 1'b0;
         tag_v1       <= 1'b0;
         tag_o0       <= '0;
         tag_o1       <= '0;
         rvalid       <= '0;
         rdata        <= '0;
         conflict_cnt <= '0;
      end else begin
         ptr    <= ptr_next;
         tag_v0 <= grant0 && !we[sel0];
         tag_o0 <= sel0;
         tag_v1 <= grant1 && !we[sel1];
         tag_o1 <= sel1;
         rvalid <= ret;
         if (tag_v0) rdata[tag_o0*DATA_WIDTH +: DATA_WIDTH] <= ram_dout_0;
         if (tag_v1) rdata[tag_o1*DATA_WIDTH +: DATA_WIDTH] <= ram_dout_1;
         if (conflict && conflict_cnt != 8'hFF) conflict_cnt <= conflict_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// tb/tb_dual_port_ram_arbiter.sv - self-checking bench with a RAM model and a queue-based reference
module tb_dual_port_ram_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] we = '0;
   logic [4*AW-1:0] addr = '0;
   logic [4*DW-1:0] wdata = '0;
   logic [3:0] gnt, rvalid;
   logic [4*DW-1:0] rdata;
   logic ram_en_0, ram_en_1, ram_we_0, ram_we_1;
   logic [AW-1:0] ram_addr_0, ram_addr_1;
   logic [DW-1:0] ram_din_0, ram_din_1, ram_dout_0, ram_dout_1;
   logic [7:0] conflict_cnt;

   logic [DW-1:0] ram [32] = '{default: '0};
   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   dual_port_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_en_0(ram_en_0), .ram_en_1(ram_en_1), .ram_we_0(ram_we_0), .ram_we_1(ram_we_1),
      .ram_addr_0(ram_addr_0), .ram_addr_1(ram_addr_1),
      .ram_din_0(ram_din_0), .ram_din_1(ram_din_1),
      .ram_dout_0(ram_dout_0), .ram_dout_1(ram_dout_1),
      .conflict_cnt(conflict_cnt)
   );

   // Read-first dual-port RAM with registered read
   always @(posedge clk) begin
      if (ram_en_0) begin
         if (ram_we_0) ram[ram_addr_0] <= ram_din_0;
         else          ram_dout_0 <= ram[ram_addr_0];
      end
      if (ram_en_1) begin
         if (ram_we_1) ram[ram_addr_1] <= ram_din_1;
         else          ram_dout_1 <= ram[ram_addr_1];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [AW-1:0] ra(input int i);
      return addr[i*AW +: AW];
   endfunction

   function automatic logic [DW-1:0] rd(input int i);
      return wdata[i*DW +: DW];
   endfunction

   typedef struct {
      int          due;
      int          owner;
      logic [31:0] val;
   } ret_t;

   ret_t        pend[$];
   logic [31:0] mmem [32] = '{default: '0};
   logic [31:0] mrdata [4] = '{default: '0};
   int          mptr = 0;
   int          mcnt = 0;

   always @(negedge clk) begin
      int order[$];
      int p0, p1;
      bit g0, g1, conf;
      logic [3:0] eg, erv;
      erv = '0;
      order.delete();
      g0 = 0; g1 = 0; conf = 0; p0 = 0; p1 = 0;
      if (rst) begin
         mptr = 0;
         mcnt = 0;
         pend.delete();
         for (int i = 0; i < 4; i++) mrdata[i] = '0;
      end else begin
         for (int q = pend.size() - 1; q >= 0; q--) begin
            if (pend[q].due == cyc) begin
               erv[pend[q].owner] = 1'b1;
               mrdata[pend[q].owner] = pend[q].val;
               pend.delete(q);
            end
         end
         for (int k = 0; k < 4; k++) if (req[(mptr + k) % 4]) order.push_back((mptr + k) % 4);
         if (order.size() > 0) begin
            g0 = 1;
            p0 = order[0];
         end
         if (order.size() > 1) begin
            p1 = order[1];
            conf = we[p0] && we[p1] && (ra(p0) == ra(p1));
            g1 = !conf;
         end
      end
      eg = '0;
      if (g0) eg[p0] = 1'b1;
      if (g1) eg[p1] = 1'b1;

      chk("gnt", 32'(gnt), 32'(eg));
      chk("rvalid", 32'(rvalid), 32'(erv));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(mcnt));
      for (int i = 0; i < 4; i++) chk("rdata", rdata[i*DW +: DW], mrdata[i]);
      chk("en0", 32'(ram_en_0), 32'(g0));
      chk("we0", 32'(ram_we_0), 32'(g0 && we[p0]));
      chk("addr0", 32'(ram_addr_0), g0 ? 32'(ra(p0)) : 32'd0);
      chk("din0", ram_din_0, g0 ? rd(p0) : 32'd0);
      chk("en1", 32'(ram_en_1), 32'(g1));
      chk("we1", 32'(ram_we_1), 32'(g1 && we[p1]));
      chk("addr1", 32'(ram_addr_1), g1 ? 32'(ra(p1)) : 32'd0);
      chk("din1", ram_din_1, g1 ? rd(p1) : 32'd0);

      if (!rst) begin
         if (g0 && !we[p0]) pend.push_back('{cyc + 2, p0, mmem[ra(p0)]});
         if (g1 && !we[p1]) pend.push_back('{cyc + 2, p1, mmem[ra(p1)]});
         if (g0 && we[p0]) mmem[ra(p0)] = rd(p0);
         if (g1 && we[p1]) mmem[ra(p1)] = rd(p1);
         if (g1)      mptr = (p1 + 1) % 4;
         else if (g0) mptr = (p0 + 1) % 4;
         if (conf && mcnt < 255) mcnt++;
      end
      cyc++;
   end

   task automatic setr(input int i, input bit w, input int a, input logic [31:0] d);
      req[i] = 1'b1;
      we[i] = w;
      addr[i*AW +: AW] = AW'(a);
      wdata[i*DW +: DW] = d;
   endtask

   task automatic drop(input int i);
      req[i] = 1'b0;
      we[i] = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic peek;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int cnt[4];
      peek;
      chk("lit_rst_cnt", 32'(conflict_cnt), 32'd0);
      chk("lit_rst_rvalid", 32'(rvalid), 32'd0);
      tick; tick;
      rst = 1'b0;

      setr(0, 1, 3, 32'hA5A5_0003);
      setr(1, 1, 4, 32'h1);
      peek;
      chk("lit_pre_gnt", 32'(gnt), 32'h3);
      tick; drop(0); drop(1);

      setr(2, 0, 3, 0);
      peek;
      chk("lit_rd_gnt", 32'(gnt), 32'h4);
      chk("lit_rd_en0", 32'(ram_en_0), 32'd1);
      tick; drop(2);
      peek; tick;
      peek;
      chk("lit_rd_rvalid", 32'(rvalid), 32'h4);
      chk("lit_rd_data", rdata[2*DW +: DW], 32'hA5A5_0003);
      tick;

      setr(3, 0, 0, 0);
      tick; drop(3);
      setr(1, 1, 7, 32'h11);
      setr(3, 0, 9, 0);
      peek;
      chk("lit_dual_gnt", 32'(gnt), 32'hA);
      chk("lit_dual_addr0", 32'(ram_addr_0), 32'd7);
      chk("lit_dual_addr1", 32'(ram_addr_1), 32'd9);
      tick; drop(1); drop(3);
      tick; tick;

      setr(0, 0, 3, 0); setr(1, 0, 4, 0); setr(2, 0, 7, 0); setr(3, 0, 9, 0);
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int f = 0; f < 6; f++) begin
         if (f == 4) begin
            for (int i = 0; i < 4; i++) drop(i);
         end
         peek;
         if (f < 4) chk("lit_fair_gnt", 32'(gnt), (f % 2 == 0) ? 32'h3 : 32'hC);
         for (int i = 0; i < 4; i++) cnt[i] += int'(rvalid[i]);
         tick;
      end
      for (int i = 0; i < 4; i++) chk("lit_fair_rvalid_cnt", 32'(cnt[i]), 32'd2);

      setr(0, 1, 5, 32'hAA);
      setr(1, 1, 5, 32'hBB);
      peek;
      chk("lit_cf_gnt", 32'(gnt), 32'h1);
      tick; drop(0);
      peek;
      chk("lit_cf_gnt2", 32'(gnt), 32'h2);
      chk("lit_cf_cnt", 32'(conflict_cnt), 32'd1);
      tick; drop(1);
      setr(2, 0, 5, 0);
      tick; drop(2);
      peek; tick;
      peek;
      chk("lit_cf_mem5", rdata[2*DW +: DW], 32'hBB);
      tick;

      setr(0, 1, 4, 32'h2);
      setr(1, 0, 4, 0);
      peek;
      chk("lit_rdw_gnt", 32'(gnt), 32'h3);
      tick; drop(0);
      peek; tick; drop(1);
      peek;
      chk("lit_rdw_old", rdata[1*DW +: DW], 32'h1);
      tick;
      peek;
      chk("lit_rdw_new", rdata[1*DW +: DW], 32'h2);
      tick;

      setr(2, 0, 3, 0);
      tick;
      rst = 1'b1;
      req = 4'hF;
      peek;
      chk("lit_rst_gnt", 32'(gnt), 32'd0);
      chk("lit_rst_en", 32'(ram_en_0 | ram_en_1), 32'd0);
      tick;
      peek;
      chk("lit_rst_rv", 32'(rvalid), 32'd0);
      chk("lit_rst_rdata2", rdata[2*DW +: DW], 32'd0);
      tick;
      rst = 1'b0;
      req = '0;
      we = '0;
      for (int f = 0; f < 3; f++) begin
         peek;
         chk("lit_post_rst_rv", 32'(rvalid), 32'd0);
         tick;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dual_port_ram_arbiter.md
# dual_port_ram_arbiter

- Four-requester round-robin arbiter that shares one 32x32 dual-port RAM (two independent read/write ports, registered read, one-cycle read latency).
- Every cycle it grants up to two requests, one per RAM port, and drives that port's enable, write-enable, address and write data.
- It captures read results and returns them to the owning requester with a valid pulse.
- It sits between the processing-element request buses and the RAM. The RAM's read and write clocks are both tied to this block's `clk`.

## Interface
- `DATA_WIDTH`, 32, data width of RAM and requesters
- `ADDR_WIDTH`, 5, RAM address width (32 words)
- `clk` in 1: single clock; also drives RAM read and write clocks
- `rst` in 1: asynchronous, active-high reset
- `req` in 4: per-requester request, held high until granted
- `we` in 4: per-requester write (1) / read (0), valid while `req` is high
- `addr` in 4*ADDR_WIDTH: requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `wdata` in 4*DATA_WIDTH: requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- `gnt` out 4: combinational one-cycle grant per requester
- `rvalid` out 4: registered one-cycle pulse, read data ready for requester i
- `rdata` out 4*DATA_WIDTH: registered read data per requester; holds until that requester's next read
- `ram_en_0`/`ram_en_1` out 1: RAM port enables
- `ram_we_0`/`ram_we_1` out 1: RAM port write enables
- `ram_addr_0`/`ram_addr_1` out ADDR_WIDTH: drive both the write and read address of the port
- `ram_din_0`/`ram_din_1` out DATA_WIDTH: RAM write data
- `ram_dout_0`/`ram_dout_1` in DATA_WIDTH: RAM registered read data
- `conflict_cnt` out 8: saturating count of same-address write-write deferrals

## Operation
- Round-robin pointer `ptr` (2 bits, reset 0). Requesters are scanned in order `ptr`, `ptr+1`, ... mod 4.
- The first requesting index found gets port 0. The next requesting index found gets port 1.
- Write-write address conflict:
  - If both selected requests are writes to the same address, port 1 is not granted that cycle.
  - Scanning does not continue to a third requester.
  - `conflict_cnt` increments, saturating at 255.
- Read and write to the same address in the same cycle are both granted. The read returns the old word; no forwarding.
- Read and read to the same address are both granted.
- `ptr` update on any grant: `ptr` becomes (highest-order granted index in scan order + 1) mod 4. With no grants, `ptr` is unchanged.
- Ungranted ports drive en=0, we=0, addr=0, din=0.
- Read-return tracking, per port:
  - A 3-bit tag {valid, owner[1:0]} is registered when a read is granted.
  - In the next cycle, `ram_dout_x` is captured into `rdata[owner]`.
  - `rvalid[owner]` is set for one cycle after that capture.
- Both ports may return to different requesters in the same cycle. The same requester cannot own both ports in one cycle.
- Write grants produce no `rvalid`.

## Timing
- Cycle T: `req`/`we`/`addr` stable → `gnt` and RAM port signals asserted combinationally in T.
  - RAM write lands at the end of T.
  - RAM read data is valid during T+1.
- T+1: tag valid; `rdata[i]` is loaded at the end of T+1.
- T+2: `rvalid[i]` = 1 for exactly one cycle, with `rdata[i]` stable.
- Read latency is 2 cycles from grant to `rvalid`. Throughput is up to 2 accesses per cycle.
- A requester may drop `req` or present a new request in T+1. Back-to-back grants to the same requester are allowed when others are idle.
- Reset values: `ptr`=0, tags invalid, `rvalid`=0, `rdata`=0, `conflict_cnt`=0.
- While `rst`=1, `gnt`=0 and all `ram_*` outputs are 0.
- Reset mid-read: in-flight tags are cleared, and no `rvalid` is issued for reads granted before reset.

## Test plan
- Single read:
  - Preload mem[3]=32'hA5A5_0003.
  - Requester 2 reads addr 3 at T → `gnt[2]` at T, `ram_en_0`=1, `rvalid[2]` at T+2, `rdata[2]`=32'hA5A5_0003.
- Dual grant with `ptr`=0:
  - Requesters 1 (write 32'h11 to addr 7) and 3 (read addr 9) request together.
  - → `gnt`=4'b1010; requester 1 on port 0, requester 3 on port 1; `ptr` becomes 0.
- Fairness:
  - All four hold read requests for 4 cycles.
  - → grant pairs {0,1}, {2,3}, {0,1}, {2,3}; every requester receives `rvalid` twice.
- Write-write conflict:
  - Requesters 0 and 1 both write addr 5 (32'hAA, 32'hBB).
  - → only `gnt[0]`, `conflict_cnt`=1; next cycle `gnt[1]`; final mem[5]=32'hBB.
- Read-during-write:
  - mem[4]=32'h1. Requester 0 writes 32'h2 to addr 4 while requester 1 reads addr 4.
  - → `rdata[1]`=32'h1; a re-read one cycle later returns 32'h2.
- Reset mid-read:
  - Assert `rst` at T+1 after a read grant at T.
  - → no `rvalid` ever; `rdata` all 0; `gnt`=0 while `rst`=1.
